// File: rtl/control_pkg.sv
// control_pkg: shared encodings for the multi-cycle main control unit.
// Optional build macro CONTROL_FSM_ILLEGAL_TRAP_EN adds the TRAP state and
// makes the illegal_op flag live; without it TRAP does not exist.
package control_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        ADDI_EX   = 4'd9,
        ADDI_WB   = 4'd10,
        JUMP      = 4'd11
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        , TRAP    = 4'd12
`endif
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_ONE = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;
    localparam logic [1:0] SRC_B_BR  = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // Moore decode of a state; mem_ready only qualifies the FETCH strobes
    // and the retire pulse of a store.
    function automatic ctrl_t state_outputs(input state_t state, input logic mem_ready);
        ctrl_t c;
        c = '0;
        case (state)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRC_B_ONE;
                c.alu_op    = ALU_ADD;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            DECODE: begin
                c.alu_src_b = SRC_B_BR;
                c.alu_op    = ALU_ADD;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = mem_ready;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_FUNCT;
            end
            ALU_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_SRC_ALUOUT;
                c.instr_done    = 1'b1;
            end
            ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            ADDI_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PC_SRC_JUMP;
                c.instr_done = 1'b1;
            end
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            TRAP: begin
                c.illegal_op = 1'b1;
            end
`endif
            default: begin
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_counter.sv
// instr_counter: wrapping retired-instruction counter, async active-high reset.
module instr_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_en_i,
    output logic [COUNT_W-1:0] count_o
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // Increment on enable; all-ones rolls over to zero silently.
    always_comb begin
        count_d = inc_en_i ? count_q + COUNT_W'(1) : count_q;
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle control unit for the 16-bit datapath; drives
// alu_op toward ALUControl plus every datapath enable and mux select.
// Build macro CONTROL_FSM_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP
// with illegal_op=1; otherwise they retire nothing and return to FETCH.
//
// state     | meaning
// ----------+------------------------------------------------------
// FETCH     | read instruction, PC+1; waits for mem_ready
// DECODE    | decode opcode, precompute branch target
// MEM_ADDR  | effective address for LW/SW
// MEM_READ  | data read; waits for mem_ready
// MEM_WB    | load result to register file (retire)
// MEM_WRITE | data write; retires on mem_ready
// EXECUTE   | R-type ALU operation
// ALU_WB    | R-type result to rd (retire)
// BRANCH    | compare and conditional PC update (retire)
// ADDI_EX   | register + immediate
// ADDI_WB   | ADDI result to rt (retire)
// JUMP      | PC <- jump target (retire)
// TRAP      | illegal opcode lock-up until reset (macro build only)
module main_control_fsm
    import control_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                i_or_d,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [1:0]          alu_op,
    output logic                instr_done,
    output logic [COUNT_W-1:0]  instr_count,
    output logic                illegal_op
);

`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = TRAP;
`else
    localparam state_t ILLEGAL_NEXT = FETCH;
`endif

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // Next-state logic; opcode is only looked at in DECODE and MEM_ADDR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (opcode == OPCODE_W'(OP_RTYPE))
                    state_d = EXECUTE;
                else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW))
                    state_d = MEM_ADDR;
                else if (opcode == OPCODE_W'(OP_BEQ))
                    state_d = BRANCH;
                else if (opcode == OPCODE_W'(OP_ADDI))
                    state_d = ADDI_EX;
                else if (opcode == OPCODE_W'(OP_J))
                    state_d = JUMP;
                else
                    state_d = ILLEGAL_NEXT;
            end
            MEM_ADDR:  state_d = (opcode == OPCODE_W'(OP_SW)) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (mem_ready) state_d = MEM_WB;
            MEM_WRITE: if (mem_ready) state_d = FETCH;
            EXECUTE:   state_d = ALU_WB;
            ADDI_EX:   state_d = ADDI_WB;
            MEM_WB,
            ALU_WB,
            ADDI_WB,
            BRANCH,
            JUMP:      state_d = FETCH;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            TRAP:      state_d = TRAP;
`endif
            default:   state_d = FETCH;
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are forced low for the whole time reset is high so no strobe
    // (including FETCH's mem_read) can leak out while the datapath resets.
    assign ctrl = reset ? '0 : state_outputs(state_q, mem_ready);

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign reg_write     = ctrl.reg_write;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;

    instr_counter #(
        .COUNT_W (COUNT_W)
    ) u_instr_counter (
        .clk      (clk),
        .reset    (reset),
        .inc_en_i (ctrl.instr_done),
        .count_o  (instr_count)
    );

endmodule
